// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester asynchronous SRAM arbiter.
// The request struct is sized for the board SRAM (20-bit word address, 16-bit data).
package sram_arb_pkg;

    localparam int WCNT_W      = 4;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [1:0]             be;
        logic [SRAM_DATA_W-1:0] wdata;
    } mreq_t;

    // Disabled byte lanes read back as zero.
    function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic [SRAM_DATA_W-1:0] d,
                                                         input logic [1:0]             be);
        return {(be[1] ? d[15:8] : 8'h00), (be[0] ? d[7:0] : 8'h00)};
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: both masters' request/response
// signals plus the arbiter's FSM state for observation.
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) ();

    // Handshake: a master raises mN_req with its fields and holds them until
    // mN_gnt pulses for one cycle (fields latched on that grant); a req still
    // high after gnt is a fresh request. mN_rvalid pulses once per completed
    // read and mN_rdata holds until that master's next read completes.
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [1:0]        m0_be;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [1:0]        m1_be;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    arb_state_e        state;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_be, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_be, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output state
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_be, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_be, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  state
    );

endinterface

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin picker: combinational winner selection plus the
// registered pointer that remembers who was granted last.
module sram_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       load,
    output logic       valid,
    output logic       winner
);

    logic ptr_q;

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~ptr_q;
            default: winner = 1'b0;
        endcase
    end

    // Pointer starts at m1 so that m0 wins the first contested pick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else if (load) begin
            ptr_q <= winner;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 16-bit SRAM between two requesters with round-robin
// arbitration and fixed setup / wait / recovery sequencing. All pins registered.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    sram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] sram_ADDR,
    inout  wire  [DATA_W-1:0] sram_DQ,
    output logic              sram_CE_N,
    output logic              sram_OE_N,
    output logic              sram_WE_N,
    output logic              sram_LB_N,
    output logic              sram_UB_N
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [WCNT_W-1:0] wcnt_q;
    mreq_t             lat_q;
    logic              win_q;

    logic              arb_valid;
    logic              arb_winner;
    logic              arb_load;
    logic [1:0]        req_vec;
    mreq_t             pick_req;

    logic [ADDR_W-1:0] addr_d;
    logic              ce_n_d;
    logic              oe_n_d;
    logic              we_n_d;
    logic              lb_n_d;
    logic              ub_n_d;
    logic              dq_oe_d;
    logic              dq_oe_q;
    logic [1:0]        gnt_d;
    logic [1:0]        gnt_q;
    logic [1:0]        rvalid_d;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              rd_capture;
    logic [DATA_W-1:0] cap_data;

    assign req_vec  = {bus.m1_req, bus.m0_req};
    assign arb_load = (state_q == IDLE) && arb_valid;

    sram_rr_arb2 u_rr (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .req    (req_vec),
        .load   (arb_load),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_comb begin
        pick_req       = '0;
        pick_req.we    = arb_winner ? bus.m1_we : bus.m0_we;
        pick_req.addr  = arb_winner ? SRAM_ADDR_W'(bus.m1_addr) : SRAM_ADDR_W'(bus.m0_addr);
        pick_req.be    = arb_winner ? bus.m1_be : bus.m0_be;
        pick_req.wdata = arb_winner ? SRAM_DATA_W'(bus.m1_wdata) : SRAM_DATA_W'(bus.m0_wdata);
    end

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_valid) state_d = ACCESS;
            ACCESS:  if (wcnt_q == '0) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and wait counter; fields are only sampled on a grant.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wcnt_q <= '0;
            lat_q  <= '0;
            win_q  <= 1'b0;
        end else if (arb_load) begin
            wcnt_q <= WCNT_W'(WAIT_CYCLES - 1);
            lat_q  <= pick_req;
            win_q  <= arb_winner;
        end else if ((state_q == ACCESS) && (wcnt_q != '0)) begin
            wcnt_q <= wcnt_q - 1'b1;
        end
    end

    // Output logic: next values of the registered pins, so each pin changes
    // on the same edge as the state it belongs to.
    always_comb begin
        addr_d   = sram_ADDR;
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        if (arb_load) begin
            gnt_d[arb_winner] = 1'b1;
            addr_d  = ADDR_W'(pick_req.addr);
            ce_n_d  = 1'b0;
            oe_n_d  = pick_req.we;
            we_n_d  = ~pick_req.we;
            lb_n_d  = ~pick_req.be[0];
            ub_n_d  = ~pick_req.be[1];
            dq_oe_d = pick_req.we;
        end else if ((state_q == ACCESS) && (state_d == ACCESS)) begin
            addr_d  = ADDR_W'(lat_q.addr);
            ce_n_d  = 1'b0;
            oe_n_d  = lat_q.we;
            we_n_d  = ~lat_q.we;
            lb_n_d  = ~lat_q.be[0];
            ub_n_d  = ~lat_q.be[1];
            dq_oe_d = lat_q.we;
        end else if (state_q == ACCESS) begin
            // Entering RECOVER: write data held one more cycle past WE_N rising.
            dq_oe_d         = lat_q.we;
            rvalid_d[win_q] = ~lat_q.we;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sram_ADDR <= '0;
            sram_CE_N <= 1'b1;
            sram_OE_N <= 1'b1;
            sram_WE_N <= 1'b1;
            sram_LB_N <= 1'b1;
            sram_UB_N <= 1'b1;
            dq_oe_q   <= 1'b0;
            gnt_q     <= 2'b00;
            rvalid_q  <= 2'b00;
        end else begin
            sram_ADDR <= addr_d;
            sram_CE_N <= ce_n_d;
            sram_OE_N <= oe_n_d;
            sram_WE_N <= we_n_d;
            sram_LB_N <= lb_n_d;
            sram_UB_N <= ub_n_d;
            dq_oe_q   <= dq_oe_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Read data is sampled on the edge that ends ACCESS, while OE_N is still low.
    assign rd_capture = (state_q == ACCESS) && (state_d == RECOVER) && !lat_q.we;
    assign cap_data   = DATA_W'(lane_mask(SRAM_DATA_W'(sram_DQ), lat_q.be));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (rd_capture) begin
            if (win_q) begin
                rdata1_q <= cap_data;
            end else begin
                rdata0_q <= cap_data;
            end
        end
    end

    assign sram_DQ = dq_oe_q ? DATA_W'(lat_q.wdata) : {DATA_W{1'bz}};

    assign bus.m0_gnt    = gnt_q[0];
    assign bus.m1_gnt    = gnt_q[1];
    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.state     = state_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the board's single 16-bit asynchronous SRAM (20-bit word address, byte-lane enables) between two Avalon-style requesters, e.g. the audio sample buffer (m0) and the processor-side DMA (m1).
- Performs 2-way round-robin arbitration and sequences each access with fixed setup, wait-state and recovery timing.
- Drives the sram_* pins directly; it is the sole owner of those pins in the top level.

Parameters:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 16, SRAM data width; must be 16, giving two byte lanes.
- WAIT_CYCLES, 2, cycles the ACCESS state lasts, i.e. strobes held active; legal range 1..15.

Ports:
- clk_clk  in  1  system clock; all logic on its rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  requester 0 access request; held until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  word address.
- m0_be  in  2  byte enables; bit0 = low byte, bit1 = high byte.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  one-cycle pulse: request accepted and fields latched.
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid.
- m0_rdata  out  DATA_W  read data, held until the next m0 read completes.
- m1_req, m1_we, m1_addr, m1_be, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to m0_*, for requester 1.
- sram_ADDR  out  ADDR_W  SRAM address.
- sram_DQ  inout  DATA_W  SRAM data bus; driven only during writes.
- sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (async, effective immediately, including mid-access):
  - Strobes: sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N all = 1.
  - sram_ADDR = 0; sram_DQ = high-Z.
  - gnt and rvalid = 0; rdata = 0.
  - RR pointer = m1, so m0 wins the first contested grant.
  - State = IDLE. Any in-flight access is dropped with no rvalid.
- Every output is registered.
- FSM states are IDLE, ACCESS and RECOVER.
- IDLE:
  - No req asserted: stay in IDLE, all strobes 1.
  - Exactly one req: grant it.
  - Both reqs: grant the requester that is not the RR pointer (the one not granted last).
  - On grant: latch we, addr, be and wdata; update the RR pointer to the winner; go to ACCESS; set wait counter = WAIT_CYCLES-1.
- ACCESS, lasting WAIT_CYCLES cycles:
  - First cycle: gnt of the winner = 1, for exactly one cycle.
  - Throughout: sram_CE_N = 0, sram_ADDR = latched addr, sram_LB_N = ~be[0], sram_UB_N = ~be[1].
  - Read: sram_OE_N = 0, sram_WE_N = 1, DQ high-Z.
  - Write: sram_OE_N = 1, sram_WE_N = 0, DQ driven with latched wdata.
  - The counter decrements each cycle. At 0, on the clock edge that leaves ACCESS, a read captures sram_DQ into the winner's rdata. Lanes with be = 0 are stored as 8'h00.
  - Then go to RECOVER.
- RECOVER, one cycle:
  - Strobes: sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N and sram_UB_N all = 1; ADDR holds its value.
  - Write: DQ stays driven this cycle for data hold, then goes high-Z.
  - Read: the winner's rvalid = 1.
  - Then go to IDLE.
- Timing:
  - req seen at cycle N gives gnt at N+1 and read rvalid at N+1+WAIT_CYCLES.
  - Occupancy is WAIT_CYCLES+2 cycles per access; there are no back-to-back accesses without a pass through IDLE.
- Request fields are sampled only in IDLE. A requester may change or drop its fields after gnt. A req dropped before gnt is simply not serviced.
- be = 2'b00 is legal: full timing still applies, no lane is enabled, a read returns 0 with rvalid, and a write is a no-op.
- A req that is held continuously after its gnt is a new request. Round-robin guarantees the other requester is served within one access.
- sram_DQ is never driven outside write ACCESS and its following RECOVER. SRAM strobes are never active in IDLE.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {IDLE, ACCESS, RECOVER};
  - localparam WCNT_W = 4;
  - per-master request struct {we, addr, be, wdata}.
- One sub-module, sram_rr_arb2: combinational 2-way round-robin pick plus the registered pointer, with inputs req[1:0] and load.
- The top instantiates sram_rr_arb2, the FSM, the wait counter, the pin registers and the tri-state.

Test Plan:
- Reset mid-write: assert reset_reset_n = 0 while sram_WE_N = 0. Within the same cycle, all strobes = 1 and DQ = Z; after release, no gnt or rvalid for the dropped access.
- m0 single write then read, WAIT_CYCLES = 2:
  - Write addr 20'h00012, wdata 16'hBEEF, be = 2'b11: gnt at N+1, sram_WE_N low for 2 cycles, DQ = BEEF through RECOVER.
  - Read back the same address: m0_rvalid at N+3 with m0_rdata = 16'hBEEF.
- Byte lanes: m1 writes be = 2'b01 with 16'h1234 to an address holding 16'hFFFF. A read with be = 2'b11 returns 16'hFF34. A read with be = 2'b10 returns 16'hFF00, with sram_LB_N = 1.
- Contention: hold m0_req and m1_req high simultaneously from reset. Grants alternate m0, m1, m0, m1, spaced 4 cycles apart, and no gnt is ever asserted on both masters.
- WAIT_CYCLES = 1 and = 15 builds: read latency req→rvalid = 2 and 16 cycles respectively; sram_CE_N low for exactly WAIT_CYCLES cycles.
- Bus safety: random traffic for 10k cycles. The SRAM model must see DQ never driven by the arbiter while sram_OE_N = 0, and never see sram_WE_N = 0 and sram_OE_N = 0 at the same time.
